// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI responder and the matching SPI master:
// FSM state encoding, default frame length and minimum sclk half-period
// (in CLOCK_50 cycles) that the oversampling front end can resolve.
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } spi_state_e;

  localparam int unsigned DefBitsTransfer   = 16;
  localparam int unsigned MinSclkHalfPeriod = 4;

endpackage : spi_pkg

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Two-flop synchronizer for one asynchronous pin plus a third flop for edge
// detection. Rise/fall strobes are single-cycle and are suppressed until the
// whole pipeline holds real pin samples, so a pin that differs from the reset
// value at reset release never produces a phantom edge.
//
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_async  asynchronous pin
//   o_level  synchronized level
//   o_rise   one-cycle strobe on a synchronized 0->1 transition
//   o_fall   one-cycle strobe on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module spi_sync_edge #(
  parameter logic ResetVal = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic [2:0] r_primed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta   <= ResetVal;
      r_sync   <= ResetVal;
      r_prev   <= ResetVal;
      r_primed <= 3'b000;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_prev   <= r_sync;
      r_primed <= {r_primed[1:0], 1'b1};
    end
  end

  // r_primed[2] is set once r_prev holds a genuine pin sample.
  assign o_level = r_sync;
  assign o_rise  = r_primed[2] & r_sync & ~r_prev;
  assign o_fall  = r_primed[2] & ~r_sync & r_prev;

endmodule : spi_sync_edge

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI responder, Mode 0, MSB first. sclk, ss_n and mosi are oversampled on
// CLOCK_50. A tx word is captured at frame start and shifted out on miso; the
// received word is presented on rx_data with rx_valid / rx_pending handshake.
//
// Ports:
//   CLOCK_50    system clock
//   rst_n       asynchronous active-low reset
//   sclk        SPI clock (idles low)
//   ss_n        slave select, active-low
//   mosi        serial data in
//   miso        serial data out, 0 while deselected
//   tx_data     word to send, captured on the ss_n falling edge
//   rx_data     last complete received word
//   rx_valid    one-cycle pulse when rx_data updates
//   rx_ack      consumer acknowledge; clears rx_pending and overrun
//   rx_pending  rx_data holds an unread word
//   overrun     sticky: frame completed while a word was still unread
//   frame_err   one-cycle pulse when ss_n rises mid-frame
//   busy        high while shifting
// -----------------------------------------------------------------------------
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned bits_transfer = DefBitsTransfer
) (
  input  logic                     CLOCK_50,
  input  logic                     rst_n,
  input  logic                     sclk,
  input  logic                     ss_n,
  input  logic                     mosi,
  output logic                     miso,
  input  logic [bits_transfer-1:0] tx_data,
  output logic [bits_transfer-1:0] rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ack,
  output logic                     rx_pending,
  output logic                     overrun,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int unsigned counter_width = $clog2(bits_transfer) + 1;
  localparam logic [counter_width-1:0] CntFull = counter_width'(bits_transfer);

  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_ss_level, w_ss_rise, w_ss_fall;
  logic w_mosi_sync, w_mosi_rise, w_mosi_fall;

  spi_sync_edge #(.ResetVal(1'b0)) u_sync_sclk (
    .i_clk   (CLOCK_50),
    .i_rst_n (rst_n),
    .i_async (sclk),
    .o_level (w_sclk_level),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_sync_edge #(.ResetVal(1'b1)) u_sync_ss (
    .i_clk   (CLOCK_50),
    .i_rst_n (rst_n),
    .i_async (ss_n),
    .o_level (w_ss_level),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall)
  );

  spi_sync_edge #(.ResetVal(1'b0)) u_sync_mosi (
    .i_clk   (CLOCK_50),
    .i_rst_n (rst_n),
    .i_async (mosi),
    .o_level (w_mosi_sync),
    .o_rise  (w_mosi_rise),
    .o_fall  (w_mosi_fall)
  );

  // Only edges of sclk/ss_n and the level of mosi are needed.
  logic w_unused;
  assign w_unused = ^{w_sclk_level, w_ss_level, w_mosi_rise, w_mosi_fall};

  spi_state_e                 r_state;
  logic [bits_transfer-1:0]   r_tx_shift;
  logic [bits_transfer-1:0]   r_rx_shift;
  logic [counter_width-1:0]   r_cnt;
  logic                       r_miso;
  logic [bits_transfer-1:0]   r_rx_data;
  logic                       r_rx_valid;
  logic                       r_rx_pending;
  logic                       r_overrun;
  logic                       r_frame_err;
  logic                       r_busy;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_tx_shift   <= '0;
      r_rx_shift   <= '0;
      r_cnt        <= '0;
      r_miso       <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_pending <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      if (rx_ack) begin
        r_rx_pending <= 1'b0;
        r_overrun    <= 1'b0;
      end

      case (r_state)
        StIdle: begin
          if (w_ss_fall) begin
            r_tx_shift <= tx_data;
            r_miso     <= tx_data[bits_transfer-1];
            r_cnt      <= '0;
            r_rx_shift <= '0;
            r_busy     <= 1'b1;
            r_state    <= StShift;
          end else if (w_ss_rise) begin
            r_miso <= 1'b0;
          end
        end

        StShift: begin
          // A full count wins over a coincident ss_rise: the frame is good.
          if (r_cnt == CntFull) begin
            r_busy  <= 1'b0;
            r_state <= StDone;
          end else if (w_ss_rise) begin
            r_frame_err <= 1'b1;
            r_miso      <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= StIdle;
          end else begin
            if (w_sclk_rise) begin
              r_rx_shift <= {r_rx_shift[bits_transfer-2:0], w_mosi_sync};
              r_cnt      <= r_cnt + counter_width'(1);
            end
            if (w_sclk_fall) begin
              r_tx_shift <= r_tx_shift << 1;
              r_miso     <= r_tx_shift[bits_transfer-2];
            end
          end
        end

        StDone: begin
          r_rx_data    <= r_rx_shift;
          r_rx_valid   <= 1'b1;
          r_rx_pending <= 1'b1;
          if (r_rx_pending && !rx_ack) begin
            r_overrun <= 1'b1;
          end
          if (w_ss_rise) begin
            r_miso <= 1'b0;
          end
          r_state <= StIdle;
        end

        default: begin
          r_busy  <= 1'b0;
          r_miso  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign miso       = r_miso;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign rx_pending = r_rx_pending;
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;

endmodule : spi_slave

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// Directed bench for spi_slave: a 16-bit instance and an 8-bit instance share
// sclk/mosi/rst_n and have separate slave selects.
// -----------------------------------------------------------------------------
module tb_spi_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk;
  logic        mosi;
  logic        ss_n16;
  logic        ss_n8;
  logic [15:0] tx16;
  logic [7:0]  tx8;
  logic        rx_ack16;
  logic        rx_ack8;

  logic        miso16, rx_valid16, rx_pending16, overrun16, frame_err16, busy16;
  logic [15:0] rx_data16;
  logic        miso8, rx_valid8, rx_pending8, overrun8, frame_err8, busy8;
  logic [7:0]  rx_data8;

  always #10 clk = ~clk;

  spi_slave #(.bits_transfer(16)) u_dut16 (
    .CLOCK_50   (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .ss_n       (ss_n16),
    .mosi       (mosi),
    .miso       (miso16),
    .tx_data    (tx16),
    .rx_data    (rx_data16),
    .rx_valid   (rx_valid16),
    .rx_ack     (rx_ack16),
    .rx_pending (rx_pending16),
    .overrun    (overrun16),
    .frame_err  (frame_err16),
    .busy       (busy16)
  );

  spi_slave #(.bits_transfer(8)) u_dut8 (
    .CLOCK_50   (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .ss_n       (ss_n8),
    .mosi       (mosi),
    .miso       (miso8),
    .tx_data    (tx8),
    .rx_data    (rx_data8),
    .rx_valid   (rx_valid8),
    .rx_ack     (rx_ack8),
    .rx_pending (rx_pending8),
    .overrun    (overrun8),
    .frame_err  (frame_err8),
    .busy       (busy8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int valid16_cnt = 0;
  int ferr16_cnt  = 0;
  int valid8_cnt  = 0;
  int ferr8_cnt   = 0;

  always @(negedge clk) begin
    if (rx_valid16)  valid16_cnt <= valid16_cnt + 1;
    if (frame_err16) ferr16_cnt  <= ferr16_cnt + 1;
    if (rx_valid8)   valid8_cnt  <= valid8_cnt + 1;
    if (frame_err8)  ferr8_cnt   <= ferr8_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ss(input bit sel8, input logic v);
    if (sel8) ss_n8 = v;
    else      ss_n16 = v;
  endtask

  task automatic pulse_ack16();
    rx_ack16 = 1'b1;
    cyc(1);
    rx_ack16 = 1'b0;
    cyc(2);
  endtask

  // Mode 0 master: mosi set while sclk low, miso sampled at each rising edge.
  task automatic spi_xfer(input bit sel8, input int nbits, input logic [31:0] word,
                          input int half, input int nsend, input bit do_select,
                          input bit keep_ss, output logic [31:0] cap, output bit busy_ok);
    cap     = '0;
    busy_ok = 1'b1;
    if (do_select) begin
      set_ss(sel8, 1'b0);
      cyc(2 * half);
    end
    for (int i = 0; i < nsend; i++) begin
      mosi = (i < nbits) ? word[nbits-1-i] : 1'b0;
      cyc(half);
      sclk    = 1'b1;
      cap     = {cap[30:0], (sel8 ? miso8 : miso16)};
      busy_ok = busy_ok & (sel8 ? busy8 : busy16);
      cyc(half);
      sclk = 1'b0;
    end
    if (!keep_ss) begin
      cyc(half);
      set_ss(sel8, 1'b1);
      cyc(2 * half + 8);
    end
  endtask

  logic [31:0] cap;
  bit          bok;
  int          v0, f0;
  logic [15:0] rw;

  initial begin
    rst_n    = 1'b0;
    sclk     = 1'b0;
    mosi     = 1'b0;
    ss_n16   = 1'b1;
    ss_n8    = 1'b1;
    tx16     = '0;
    tx8      = '0;
    rx_ack16 = 1'b0;
    rx_ack8  = 1'b0;
    cyc(5);

    check_eq("rst_miso",       32'(miso16),       32'h0);
    check_eq("rst_rx_data",    32'(rx_data16),    32'h0);
    check_eq("rst_rx_valid",   32'(rx_valid16),   32'h0);
    check_eq("rst_rx_pending", 32'(rx_pending16), 32'h0);
    check_eq("rst_overrun",    32'(overrun16),    32'h0);
    check_eq("rst_frame_err",  32'(frame_err16),  32'h0);
    check_eq("rst_busy",       32'(busy16),       32'h0);
    rst_n = 1'b1;
    cyc(5);

    // Slow frame, sclk = CLOCK_50/400.
    tx16 = 16'hBEEF;
    v0   = valid16_cnt;
    spi_xfer(1'b0, 16, 32'hDEAD, 200, 16, 1'b1, 1'b0, cap, bok);
    check_eq("slow_rx_data",  32'(rx_data16), 32'hDEAD);
    check_eq("slow_nvalid",   32'(valid16_cnt - v0), 32'd1);
    check_eq("slow_miso",     cap[15:0], 32'hBEEF);
    check_eq("slow_busy",     32'(bok), 32'd1);
    check_eq("slow_pending",  32'(rx_pending16), 32'd1);
    check_eq("slow_idle_miso", 32'(miso16), 32'd0);
    pulse_ack16();
    check_eq("slow_ack_pending", 32'(rx_pending16), 32'd0);

    // Back-to-back frames without acknowledge -> overrun.
    tx16 = 16'h0000;
    v0   = valid16_cnt;
    spi_xfer(1'b0, 16, 32'h1234, 20, 16, 1'b1, 1'b0, cap, bok);
    check_eq("b2b_first_data",    32'(rx_data16), 32'h1234);
    check_eq("b2b_first_overrun", 32'(overrun16), 32'd0);
    spi_xfer(1'b0, 16, 32'h5678, 20, 16, 1'b1, 1'b0, cap, bok);
    check_eq("b2b_second_data", 32'(rx_data16), 32'h5678);
    check_eq("b2b_nvalid",      32'(valid16_cnt - v0), 32'd2);
    check_eq("b2b_overrun",     32'(overrun16), 32'd1);
    pulse_ack16();
    check_eq("b2b_ack_overrun", 32'(overrun16), 32'd0);
    check_eq("b2b_ack_pending", 32'(rx_pending16), 32'd0);

    // Short frame: 7 bits then deselect.
    v0 = valid16_cnt;
    f0 = ferr16_cnt;
    spi_xfer(1'b0, 16, 32'hFFFF, 20, 7, 1'b1, 1'b0, cap, bok);
    check_eq("short_ferr",    32'(ferr16_cnt - f0), 32'd1);
    check_eq("short_nvalid",  32'(valid16_cnt - v0), 32'd0);
    check_eq("short_rx_data", 32'(rx_data16), 32'h5678);
    check_eq("short_busy",    32'(busy16), 32'd0);
    tx16 = 16'h5A5A;
    spi_xfer(1'b0, 16, 32'hA5A5, 20, 16, 1'b1, 1'b0, cap, bok);
    check_eq("after_short_data", 32'(rx_data16), 32'hA5A5);
    check_eq("after_short_miso", cap[15:0], 32'h5A5A);
    pulse_ack16();

    // Reset after 9 bits with ss_n still low.
    tx16 = 16'hFFFF;
    spi_xfer(1'b0, 16, 32'hC3C3, 20, 9, 1'b1, 1'b1, cap, bok);
    check_eq("mid_busy_pre", 32'(busy16), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_miso",    32'(miso16),       32'h0);
    check_eq("mid_rst_rx_data", 32'(rx_data16),    32'h0);
    check_eq("mid_rst_pending", 32'(rx_pending16), 32'h0);
    check_eq("mid_rst_overrun", 32'(overrun16),    32'h0);
    check_eq("mid_rst_busy",    32'(busy16),       32'h0);
    cyc(3);
    rst_n = 1'b1;
    v0 = valid16_cnt;
    f0 = ferr16_cnt;
    cyc(10);
    spi_xfer(1'b0, 16, 32'hFFFF, 8, 4, 1'b0, 1'b1, cap, bok);
    cyc(10);
    check_eq("post_rst_busy",   32'(busy16), 32'd0);
    check_eq("post_rst_nvalid", 32'(valid16_cnt - v0), 32'd0);
    check_eq("post_rst_miso",   32'(miso16), 32'd0);
    ss_n16 = 1'b1;
    cyc(12);
    check_eq("post_rst_ferr", 32'(ferr16_cnt - f0), 32'd0);
    tx16 = 16'hF0F0;
    spi_xfer(1'b0, 16, 32'h0F0F, 20, 16, 1'b1, 1'b0, cap, bok);
    check_eq("post_rst_data", 32'(rx_data16), 32'h0F0F);
    check_eq("post_rst_txd",  cap[15:0], 32'hF0F0);
    pulse_ack16();

    // Maximum rate, sclk = CLOCK_50/8, random words.
    for (int k = 0; k < 200; k++) begin
      tx16 = 16'($urandom);
      rw   = 16'($urandom);
      spi_xfer(1'b0, 16, {16'h0, rw}, 4, 16, 1'b1, 1'b0, cap, bok);
      check_eq("fast_rx", 32'(rx_data16), 32'(rw));
      check_eq("fast_tx", cap[15:0], 32'(tx16));
      pulse_ack16();
    end
    check_eq("fast_overrun", 32'(overrun16), 32'd0);

    // 8-bit instance: one frame, then extra sclk edges with ss_n held low.
    tx8 = 8'h96;
    v0  = valid8_cnt;
    f0  = ferr8_cnt;
    spi_xfer(1'b1, 8, 32'h3C, 4, 8, 1'b1, 1'b1, cap, bok);
    check_eq("b8_miso", cap[7:0], 32'h96);
    check_eq("b8_busy", 32'(bok), 32'd1);
    begin
      logic [31:0] cap2;
      bit          bok2;
      spi_xfer(1'b1, 8, 32'hFF, 4, 8, 1'b0, 1'b0, cap2, bok2);
    end
    check_eq("b8_rx_data", 32'(rx_data8), 32'h3C);
    check_eq("b8_nvalid",  32'(valid8_cnt - v0), 32'd1);
    check_eq("b8_ferr",    32'(ferr8_cnt - f0), 32'd0);
    check_eq("b8_idle_busy", 32'(busy8), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_spi_slave

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (Mode 0, MSB first) for the FPGA-side SPI master links of the alarm system.
- Oversamples the external sclk, ss_n and mosi pins on CLOCK_50.
- Shifts a parallel tx word out on miso and assembles a parallel rx word from mosi.
- Flags completed frames, short frames and unread-word overruns to the system logic.

Parameters:
- bits_transfer, 16, frame length in bits; legal range 2..32.
- counter_width, $clog2(bits_transfer)+1, width of the bit counter; derived, not overridden.

Ports:
- CLOCK_50  input  1  50 MHz system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- sclk  input  1  SPI clock from master, idles low, asynchronous to CLOCK_50.
- ss_n  input  1  slave select from master, active-low, asynchronous.
- mosi  input  1  serial data from master, asynchronous.
- miso  output  1  serial data to master; driven 0 while deselected (no tristate).
- tx_data  input  bits_transfer  word to send; captured at frame start.
- rx_data  output  bits_transfer  last complete received word.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- rx_ack  input  1  consumer has read rx_data; clears rx_pending.
- rx_pending  output  1  rx_data holds an unread word.
- overrun  output  1  sticky; set when a frame completes while rx_pending=1; cleared by rx_ack.
- frame_err  output  1  one-cycle pulse when ss_n deasserts mid-frame.
- busy  output  1  high while the FSM is in SHIFT.

Behaviour:
- Reset values: miso=0, rx_data=0, rx_valid=0, rx_pending=0, overrun=0, frame_err=0, busy=0, state=IDLE, shift registers and counter=0.
- Reset values of the synchronizer flops: sclk=0, ss_n=1, mosi=0.
- Synchronizers:
  - sclk, ss_n and mosi each pass through a 2-flop synchronizer.
  - A third flop per signal provides edge detection.
  - Edge events (sclk_rise, sclk_fall, ss_fall, ss_rise) are single-cycle strobes, 3 CLOCK_50 cycles after the pin transition.
  - Supported sclk frequency ≤ CLOCK_50/8; sclk high and low phases must each last ≥ 4 CLOCK_50 cycles.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, miso=0.
  - On ss_fall: load tx_shift<=tx_data, drive miso<=tx_data[MSB] in the same cycle, clear bit counter and rx_shift, go to SHIFT.
- SHIFT:
  - busy=1.
  - On sclk_rise: rx_shift<={rx_shift[bits_transfer-2:0], mosi_sync}, and bit counter +1.
  - On sclk_fall with counter < bits_transfer: shift tx_shift left, miso<=next bit.
  - When counter reaches bits_transfer (evaluated the cycle after the last sclk_rise): go to DONE.
  - On ss_rise before counter reaches bits_transfer: pulse frame_err, leave rx_data untouched, go to IDLE, miso<=0.
- DONE:
  - Single cycle: rx_data<=rx_shift, rx_valid=1, rx_pending<=1.
  - If rx_pending was already 1 and rx_ack is low that cycle: overrun<=1 (new word still overwrites).
  - Then go to IDLE; miso is held at the last bit until the ss_rise strobe, then 0.
- Latency: rx_valid rises 5 CLOCK_50 cycles after the final sclk rising edge at the pin.
- Extra sclk edges after the full word and before ss_rise are ignored.
- Simultaneous events:
  - rx_ack in the same cycle as DONE: pending stays 1, overrun not set.
  - ss_rise in the same cycle as DONE: treated as a good frame, no frame_err.
- ss_n low at reset release: no frame starts until a fresh ss_fall is seen.
- Reset mid-frame: all state cleared immediately; the partial word is discarded.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package spi_pkg: state encoding (IDLE/SHIFT/DONE, 2-bit), default bits_transfer=16, minimum sclk half-period constant (4). The master adopts the same package.
- One sub-module: spi_sync_edge (2-flop synchronizer + edge detector, outputs sync level, rise and fall strobes), instantiated three times.

Test Plan:
- Reset, then a 16-bit frame at sclk=CLOCK_50/400, master sends 16'hDEAD, tx_data=16'hBEEF -> rx_data=16'hDEAD with one rx_valid pulse; bench captures 16'hBEEF on miso sampled at sclk rising edges; busy high for the whole frame.
- Two back-to-back frames (16'h1234, 16'h5678) with no rx_ack -> second rx_valid, rx_data=16'h5678, overrun=1; rx_ack then clears overrun and rx_pending.
- ss_n raised after 7 sclk cycles -> frame_err pulse, rx_data unchanged, no rx_valid; the next full frame 16'hA5A5 is received correctly.
- rst_n asserted mid-frame after 9 bits -> all outputs at reset values immediately.
  - After release with ss_n still low: no frame activity.
  - A fresh ss_n cycle with 16'h0F0F is received correctly.
- Maximum rate sclk=CLOCK_50/8 with random mosi/tx_data over 200 frames -> every rx_data matches, miso stream matches tx_data.
- Parameter bits_transfer=8: frame 8'h3C -> rx_data=8'h3C; ss_n held low for extra sclk edges after bit 8 -> no second rx_valid.
